// File: rtl/rsc_encoder_if.sv
// rsc_encoder_if: bit-serial handshake and code-pair bus for the RSC encoder
interface rsc_encoder_if;
  logic Data_In;
  logic Data_Valid_In;
  logic Frame_End;
  logic Data_Ready;
  logic sys;
  logic parity;
  logic Data_Valid;
  logic Encoder_done;
  modport master (
    output Data_In, Data_Valid_In, Frame_End,
    input  Data_Ready, sys, parity, Data_Valid, Encoder_done
  );
  modport slave (
    input  Data_In, Data_Valid_In, Frame_End,
    output Data_Ready, sys, parity, Data_Valid, Encoder_done
  );
endinterface

// File: rtl/rsc_encoder.sv
// rsc_encoder: rate-1/2 K=3 recursive systematic convolutional encoder (7,5 octal) with trellis termination
module rsc_encoder #(
  parameter int MAX_LEN = 40
) (
  input logic         Turbo_clk,
  input logic         rst,
  rsc_encoder_if.slave bus
);
  localparam int CW = $clog2(MAX_LEN + 1);
  typedef enum logic [1:0] {IDLE, ENCODE, TAIL1, TAIL2} state_t;
  state_t        state;
  logic          s1, s2;
  logic [CW-1:0] cnt;
  logic          tail, accept, d, a, last;
  logic [CW-1:0] cnt_next;
  assign tail           = state == TAIL1 || state == TAIL2;
  assign bus.Data_Ready = !tail;
  assign accept         = bus.Data_Valid_In && !tail;
  // Tail bits cancel the feedback so two of them return the trellis to zero
  assign d              = tail ? s1 ^ s2 : bus.Data_In;
  assign a              = d ^ s1 ^ s2;
  assign cnt_next       = state == IDLE ? CW'(1) : cnt + CW'(1);
  assign last           = bus.Frame_End || cnt_next == CW'(MAX_LEN);
  // Trellis, output pair and frame-control state machine
  always_ff @(posedge Turbo_clk or negedge rst)
    if (!rst) begin
      state            <= IDLE;
      s1               <= 1'b0;
      s2               <= 1'b0;
      cnt              <= '0;
      bus.sys          <= 1'b0;
      bus.parity       <= 1'b0;
      bus.Data_Valid   <= 1'b0;
      bus.Encoder_done <= 1'b0;
    end else begin
      bus.Encoder_done <= state == TAIL2;
      bus.Data_Valid   <= accept || tail;
      if (accept || tail) begin
        bus.sys    <= d;
        bus.parity <= a ^ s2;
        s1         <= a;
        s2         <= s1;
      end
      case (state)
        IDLE, ENCODE:
          if (accept) begin
            cnt   <= cnt_next;
            state <= last ? TAIL1 : ENCODE;
          end
        TAIL1: state <= TAIL2;
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
endmodule

// File: tb/tb_rsc_encoder.sv
// tb_rsc_encoder: directed table-driven check of the RSC encoder with hand-computed code pairs
module tb_rsc_encoder;
  typedef struct {
    logic [2:0] in;
    logic [4:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t t_main [28];
  vec_t t_max  [7];
  rsc_encoder_if bus ();
  rsc_encoder_if b4 ();
  rsc_encoder u_dut (.Turbo_clk(clk), .rst(rst), .bus(bus.slave));
  rsc_encoder #(.MAX_LEN(4)) u_max4 (.Turbo_clk(clk), .rst(rst), .bus(b4.slave));
  always #5 clk = ~clk;
  function automatic logic [4:0] outs(input bit u);
    return u ? {b4.sys, b4.parity, b4.Data_Valid, b4.Encoder_done, b4.Data_Ready}
             : {bus.sys, bus.parity, bus.Data_Valid, bus.Encoder_done, bus.Data_Ready};
  endfunction
  task automatic check(input string tag, input int i, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] {sys,parity,valid,done,ready} got %b want %b", tag, i, got, exp);
    end
  endtask
  task automatic run(input vec_t e, input bit u, input int i, input string tag);
    @(negedge clk);
    if (u) {b4.Data_In, b4.Data_Valid_In, b4.Frame_End} = e.in;
    else {bus.Data_In, bus.Data_Valid_In, bus.Frame_End} = e.in;
    @(posedge clk);
    #1;
    check(tag, i, outs(u), e.exp);
  endtask
  initial begin
    // in = {d, valid_in, frame_end}; exp = {sys, parity, valid, done, ready}
    t_main[0]  = '{3'b110, 5'b11101};
    t_main[1]  = '{3'b110, 5'b10101};
    t_main[2]  = '{3'b110, 5'b11101};
    t_main[3]  = '{3'b111, 5'b11100};
    t_main[4]  = '{3'b000, 5'b10100};
    t_main[5]  = '{3'b000, 5'b11111};
    t_main[6]  = '{3'b000, 5'b11001};
    t_main[7]  = '{3'b111, 5'b11100};
    t_main[8]  = '{3'b000, 5'b10100};
    t_main[9]  = '{3'b000, 5'b11111};
    t_main[10] = '{3'b011, 5'b00100};
    t_main[11] = '{3'b111, 5'b00100};
    t_main[12] = '{3'b110, 5'b00111};
    t_main[13] = '{3'b110, 5'b11101};
    t_main[14] = '{3'b001, 5'b11001};
    t_main[15] = '{3'b111, 5'b10100};
    t_main[16] = '{3'b000, 5'b11100};
    t_main[17] = '{3'b000, 5'b00111};
    t_main[18] = '{3'b110, 5'b11101};
    t_main[19] = '{3'b010, 5'b01101};
    t_main[20] = '{3'b111, 5'b10100};
    t_main[21] = '{3'b110, 5'b01100};
    t_main[22] = '{3'b110, 5'b11111};
    t_main[23] = '{3'b110, 5'b11101};
    t_main[24] = '{3'b010, 5'b01101};
    t_main[25] = '{3'b111, 5'b10100};
    t_main[26] = '{3'b000, 5'b01100};
    t_main[27] = '{3'b000, 5'b11111};
    t_max[0]   = '{3'b110, 5'b11101};
    t_max[1]   = '{3'b110, 5'b10101};
    t_max[2]   = '{3'b110, 5'b11101};
    t_max[3]   = '{3'b110, 5'b11100};
    t_max[4]   = '{3'b110, 5'b10100};
    t_max[5]   = '{3'b110, 5'b11111};
    t_max[6]   = '{3'b110, 5'b11101};
    {bus.Data_In, bus.Data_Valid_In, bus.Frame_End} = 3'b000;
    {b4.Data_In, b4.Data_Valid_In, b4.Frame_End}    = 3'b000;
    #1;
    check("reset_async", 0, outs(0), 5'b00001);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", 0, outs(0), 5'b00001);
    check("reset_held_max4", 0, outs(1), 5'b00001);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 28; i++) run(t_main[i], 1'b0, i, "main");
    run(t_main[0], 1'b0, 0, "abort");
    run(t_main[1], 1'b0, 1, "abort");
    #2;
    {bus.Data_In, bus.Data_Valid_In, bus.Frame_End} = 3'b000;
    rst = 1'b0;
    #1;
    check("mid_frame_reset", 0, outs(0), 5'b00001);
    @(posedge clk);
    #1;
    check("mid_frame_reset", 1, outs(0), 5'b00001);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 7; i++) run(t_main[i], 1'b0, i, "after_reset");
    for (int i = 0; i < 7; i++) run(t_max[i], 1'b1, i, "max_len4");
    @(negedge clk);
    {b4.Data_In, b4.Data_Valid_In, b4.Frame_End} = 3'b000;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
